order_dispatcher: RTL and testbench

- Consumer on the read side of the order cache FIFO, in the system_clk domain.
- Pops one order at a time and waits out the cache's fixed read latency until the registered fields are stable.
- Decodes the 3-bit opcode, issues a one-cycle start pulse to the matching compute engine, waits for that engine's done, then retires the order with its id.
- Only one order is in flight; the next pop happens only after retire.

---
 rtl/order_dispatcher_pkg.sv | 27 ++
 rtl/order_dispatcher.sv | 159 +++++++++++++++
 tb/tb_order_dispatcher.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/order_dispatcher_pkg.sv
// order_dispatcher_pkg
//   Shared definitions for the order dispatcher: opcode encodings, the
//   controller state encoding and the default engine count / watchdog width.
//   No ports; imported by order_dispatcher.

package order_dispatcher_pkg;

    // Opcode field values as stored in the order cache.
    localparam logic [2:0] OP_CONV     = 3'd0;
    localparam logic [2:0] OP_POOL     = 3'd1;
    localparam logic [2:0] OP_UPSAMPLE = 3'd2;
    localparam logic [2:0] OP_ADD      = 3'd3;
    localparam logic [2:0] OP_FINISH   = 3'd7;

    localparam int NUM_ENGINE_DEF = 4;
    localparam int TO_W_DEF       = 24;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_R = 3'd1,
        LATCH  = 3'd2,
        ISSUE  = 3'd3,
        RUN    = 3'd4,
        RETIRE = 3'd5
    } state_t;

endpackage

// File: rtl/order_dispatcher.sv
// order_dispatcher
//   Read-side consumer of the order cache FIFO. Pops one order, waits out the
//   cache read latency, decodes the opcode, pulses the matching engine start,
//   waits for that engine's done (or the watchdog) and retires the order.
//   Exactly one order is in flight at a time.
//
// Ports
//   system_clk     clock
//   rst_n          asynchronous active-low reset
//   dispatch_en    allow new pops
//   pop_order_en   pop request to the cache (combinational, IDLE only)
//   order_valid    cache accepted the pop this cycle
//   order_valid_r  order_valid delayed by one cycle
//   order, id      opcode / id fields, stable the cycle after order_valid_r
//   engine_start   one-hot, one-cycle start pulse per engine
//   engine_done    one-cycle done pulse per engine
//   busy           an order is in flight
//   retire_valid   one-cycle retire pulse
//   retire_id      id of the last retired order (held)
//   retire_err     illegal opcode or watchdog timeout, qualified by retire_valid
//   finish         sticky, set when the finish opcode retires
//   order_count    retired orders, wraps modulo 2^32

module order_dispatcher
    import order_dispatcher_pkg::*;
#(
    parameter int         NUM_ENGINE = NUM_ENGINE_DEF,
    parameter logic [2:0] FINISH_OP  = OP_FINISH,
    parameter int         TO_W       = TO_W_DEF
) (
    input  logic                  system_clk,
    input  logic                  rst_n,
    input  logic                  dispatch_en,
    output logic                  pop_order_en,
    input  logic                  order_valid,
    input  logic                  order_valid_r,
    input  logic [2:0]            order,
    input  logic [31:0]           id,
    output logic [NUM_ENGINE-1:0] engine_start,
    input  logic [NUM_ENGINE-1:0] engine_done,
    output logic                  busy,
    output logic                  retire_valid,
    output logic [31:0]           retire_id,
    output logic                  retire_err,
    output logic                  finish,
    output logic [31:0]           order_count
);

    localparam int ENG_W = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
    localparam logic [NUM_ENGINE-1:0] START_ONE = NUM_ENGINE'(1);
    // The counter steps to all-ones on the cycle it leaves RUN, so the exit
    // test looks at the value one below the limit.
    localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    state_t           state;
    logic [2:0]       op_q;
    logic [31:0]      id_q;
    logic [TO_W-1:0]  watchdog;

    logic             order_is_engine;
    logic             op_is_engine;
    logic [ENG_W-1:0] op_idx;
    logic             op_done;

    assign order_is_engine = int'(order) < NUM_ENGINE;
    assign op_is_engine    = int'(op_q) < NUM_ENGINE;
    assign op_idx          = op_q[ENG_W-1:0];
    assign op_done         = engine_done[op_idx];

    // NOTE: pop_order_en is the one combinational output, so the cache sees the
    // pop in the same cycle the dispatcher returns to IDLE; no bubble per order.
    assign pop_order_en = (state == IDLE) && dispatch_en && !finish;

    // NOTE: all state and outputs below use non-blocking assignments so every
    // branch reads the pre-edge values, regardless of statement order.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            op_q         <= '0;
            id_q         <= '0;
            watchdog     <= '0;
            engine_start <= '0;
            retire_valid <= 1'b0;
            retire_id    <= '0;
            retire_err   <= 1'b0;
            finish       <= 1'b0;
            order_count  <= '0;
        end else begin
            engine_start <= '0;
            retire_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (order_valid) begin
                        state <= WAIT_R;
                        busy  <= 1'b1;
                    end
                end

                WAIT_R: begin
                    if (order_valid_r) begin
                        state <= LATCH;
                    end
                end

                LATCH: begin
                    op_q  <= order;
                    id_q  <= id;
                    state <= ISSUE;
                    // Decoding the raw field here lets the registered start
                    // pulse sit exactly in the ISSUE cycle.
                    if (order_is_engine) begin
                        engine_start <= START_ONE << order;
                    end
                end

                ISSUE: begin
                    if (op_is_engine) begin
                        watchdog <= '0;
                        state    <= RUN;
                    end else begin
                        state        <= RETIRE;
                        retire_valid <= 1'b1;
                        retire_id    <= id_q;
                        retire_err   <= (op_q != FINISH_OP);
                        order_count  <= order_count + 32'd1;
                        if (op_q == FINISH_OP) begin
                            finish <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    watchdog <= watchdog + TO_W'(1);
                    // A done in the timeout cycle still counts as success.
                    if (op_done || (watchdog == WD_LAST)) begin
                        state        <= RETIRE;
                        retire_valid <= 1'b1;
                        retire_id    <= id_q;
                        retire_err   <= !op_done;
                        order_count  <= order_count + 32'd1;
                    end
                end

                RETIRE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_order_dispatcher.sv
// tb_order_dispatcher
//   Directed bench for order_dispatcher with a small order-cache model, an
//   engine model with programmable done delay, and scoreboards for the
//   expected start vectors and retire records.

module tb_order_dispatcher;
    import order_dispatcher_pkg::*;

    typedef struct {
        logic [31:0] rid;
        logic        err;
        int          lat;   // cycles from start pulse to retire pulse, 0 = unchecked
    } ret_t;

    logic        system_clk = 1'b0;
    logic        rst_n;
    logic        dispatch_en;
    logic        pop_order_en;
    logic        order_valid;
    logic        order_valid_r;
    logic [2:0]  order;
    logic [31:0] id;
    logic [3:0]  engine_start;
    logic [3:0]  engine_done;
    logic        busy;
    logic        retire_valid;
    logic [31:0] retire_id;
    logic        retire_err;
    logic        finish;
    logic [31:0] order_count;

    int n_checks = 0;
    int n_fail   = 0;

    order_dispatcher #(.NUM_ENGINE(4), .FINISH_OP(OP_FINISH), .TO_W(4)) dut (
        .system_clk   (system_clk),
        .rst_n        (rst_n),
        .dispatch_en  (dispatch_en),
        .pop_order_en (pop_order_en),
        .order_valid  (order_valid),
        .order_valid_r(order_valid_r),
        .order        (order),
        .id           (id),
        .engine_start (engine_start),
        .engine_done  (engine_done),
        .busy         (busy),
        .retire_valid (retire_valid),
        .retire_id    (retire_id),
        .retire_err   (retire_err),
        .finish       (finish),
        .order_count  (order_count)
    );

    always #5 system_clk = ~system_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- order cache model ----------------
    logic [2:0]  c_op [0:31];
    logic [31:0] c_id [0:31];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [2:0]  hold_op;
    logic [31:0] hold_id;

    assign order_valid = pop_order_en && (wr_ptr != rd_ptr);

    initial begin
        order_valid_r = 1'b0;
        order = 3'd0;
        id = 32'd0;
    end

    always @(posedge system_clk) begin
        order_valid_r <= order_valid;
        if (order_valid) begin
            hold_op <= c_op[rd_ptr % 32];
            hold_id <= c_id[rd_ptr % 32];
            rd_ptr  <= rd_ptr + 1;
        end
        if (order_valid_r) begin
            order <= hold_op;
            id    <= hold_id;
        end
    end

    // ---------------- engine model ----------------
    int         done_delay = 10;   // 0 = engine never answers
    int         eng_wait   = 0;
    logic [3:0] eng_sel    = 4'b0;
    logic [3:0] eng_done_m = 4'b0;
    logic [3:0] stray_done = 4'b0;

    assign engine_done = eng_done_m | stray_done;

    always @(posedge system_clk) begin
        eng_done_m <= 4'b0;
        if (eng_wait > 0) begin
            if (eng_wait == 1) eng_done_m <= eng_sel;
            eng_wait <= eng_wait - 1;
        end
        if (engine_start != 4'b0 && done_delay > 0) begin
            if (done_delay == 1) begin
                eng_done_m <= engine_start;
            end else begin
                eng_wait <= done_delay - 1;
                eng_sel  <= engine_start;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [3:0] exp_start [$];
    ret_t       exp_ret   [$];
    int cyc            = 0;
    int last_pop_cyc   = 0;
    int last_start_cyc = 0;
    int last_ret_cyc   = 0;
    int prev_ret_cyc   = 0;
    int start_seen     = 0;
    int ret_seen       = 0;
    logic [31:0] exp_count = 32'd0;

    always @(posedge system_clk) cyc <= cyc + 1;

    always @(negedge system_clk) begin
        if (!rst_n) exp_count = 32'd0;
        if (order_valid) last_pop_cyc = cyc;
        if (engine_start != 4'b0) begin
            if (exp_start.size() == 0) begin
                check("start_unexpected", 64'(engine_start), 64'd0);
            end else begin
                check("start_vec", 64'(engine_start), 64'(exp_start.pop_front()));
                check("start_latency", 64'(cyc - last_pop_cyc), 64'd3);
            end
            last_start_cyc = cyc;
            start_seen++;
        end
        if (retire_valid) begin
            exp_count = exp_count + 32'd1;
            if (exp_ret.size() == 0) begin
                check("retire_unexpected", 64'(retire_valid), 64'd0);
            end else begin
                ret_t r;
                r = exp_ret.pop_front();
                check("retire_id", 64'(retire_id), 64'(r.rid));
                check("retire_err", 64'(retire_err), 64'(r.err));
                check("order_count", 64'(order_count), 64'(exp_count));
                if (r.lat != 0) check("retire_latency", 64'(cyc - last_start_cyc), 64'(r.lat));
            end
            prev_ret_cyc = last_ret_cyc;
            last_ret_cyc = cyc;
            ret_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge system_clk);
            #1;
        end
    endtask

    task automatic push_order(input logic [2:0] op, input logic [31:0] oid,
                              input logic [3:0] st, input logic expect_ret,
                              input logic err, input int lat);
        ret_t r;
        c_op[wr_ptr % 32] = op;
        c_id[wr_ptr % 32] = oid;
        wr_ptr++;
        if (st != 4'b0) exp_start.push_back(st);
        if (expect_ret) begin
            r.rid = oid;
            r.err = err;
            r.lat = lat;
            exp_ret.push_back(r);
        end
    endtask

    task automatic wait_retires(input string tag, input int target, input int budget);
        while (ret_seen < target && budget > 0) begin
            tick(1);
            budget--;
        end
        check(tag, 64'(ret_seen), 64'(target));
    endtask

    task automatic wait_starts(input string tag, input int target, input int budget);
        while (start_seen < target && budget > 0) begin
            tick(1);
            budget--;
        end
        check(tag, 64'(start_seen), 64'(target));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int rets;
        int starts;
        rst_n = 1'b0;
        dispatch_en = 1'b0;
        tick(3);

        // Reset state
        check("rst_pop", 64'(pop_order_en), 64'd0);
        check("rst_start", 64'(engine_start), 64'd0);
        check("rst_retire_valid", 64'(retire_valid), 64'd0);
        check("rst_retire_err", 64'(retire_err), 64'd0);
        check("rst_retire_id", 64'(retire_id), 64'd0);
        check("rst_finish", 64'(finish), 64'd0);
        check("rst_count", 64'(order_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick(1);

        // Empty cache: pop requested, nothing happens
        dispatch_en = 1'b1;
        tick(3);
        check("empty_pop_en", 64'(pop_order_en), 64'd1);
        check("empty_busy", 64'(busy), 64'd0);

        // Data present but dispatch disabled: no pop
        dispatch_en = 1'b0;
        push_order(OP_CONV, 32'h11, 4'b0001, 1'b1, 1'b0, 11);
        tick(5);
        check("disabled_no_pop", 64'(rd_ptr), 64'd0);
        check("disabled_busy", 64'(busy), 64'd0);

        // Single conv order, engine 0 done 10 cycles after start
        done_delay = 10;
        dispatch_en = 1'b1;
        wait_retires("conv_retire", 1, 40);
        tick(2);
        check("conv_busy_after", 64'(busy), 64'd0);

        // Back-to-back orders, engines done after 2 cycles
        done_delay = 2;
        push_order(OP_POOL, 32'd1, 4'b0010, 1'b1, 1'b0, 3);
        push_order(OP_UPSAMPLE, 32'd2, 4'b0100, 1'b1, 1'b0, 3);
        push_order(OP_ADD, 32'd3, 4'b1000, 1'b1, 1'b0, 3);
        wait_retires("b2b_retire", 4, 60);
        check("b2b_pops", 64'(rd_ptr), 64'd4);

        // Drop dispatch_en while in RUN: order still completes, next not popped
        done_delay = 10;
        starts = start_seen;
        rets = ret_seen;
        push_order(OP_POOL, 32'h21, 4'b0010, 1'b1, 1'b0, 11);
        push_order(OP_UPSAMPLE, 32'h22, 4'b0100, 1'b1, 1'b0, 11);
        wait_starts("drop_start", starts + 1, 20);
        tick(2);
        dispatch_en = 1'b0;
        wait_retires("drop_retire", rets + 1, 30);
        tick(4);
        check("drop_no_pop", 64'(rd_ptr), 64'(wr_ptr - 1));
        check("drop_busy", 64'(busy), 64'd0);
        dispatch_en = 1'b1;
        wait_retires("drop_next_retire", rets + 2, 40);

        // Watchdog: engine never answers, stray done on other engines
        done_delay = 0;
        starts = start_seen;
        rets = ret_seen;
        push_order(OP_UPSAMPLE, 32'h31, 4'b0100, 1'b1, 1'b1, 16);
        wait_starts("wd_start", starts + 1, 20);
        tick(3);
        stray_done = 4'b1011;
        tick(1);
        stray_done = 4'b0000;
        wait_retires("wd_retire", rets + 1, 40);

        // Reset mid-RUN
        starts = start_seen;
        rets = ret_seen;
        push_order(OP_POOL, 32'h41, 4'b0010, 1'b0, 1'b0, 0);
        wait_starts("rstrun_start", starts + 1, 20);
        tick(3);
        check("rstrun_busy_pre", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstrun_busy", 64'(busy), 64'd0);
        check("rstrun_start_vec", 64'(engine_start), 64'd0);
        check("rstrun_count", 64'(order_count), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("rstrun_no_retire", 64'(ret_seen), 64'(rets));
        done_delay = 3;
        push_order(OP_ADD, 32'h42, 4'b1000, 1'b1, 1'b0, 4);
        wait_retires("rstrun_next_retire", rets + 1, 30);

        // Illegal opcode, then finish, then an order that must never pop
        rets = ret_seen;
        starts = start_seen;
        push_order(3'd5, 32'hA, 4'b0000, 1'b1, 1'b1, 0);
        push_order(OP_FINISH, 32'hB, 4'b0000, 1'b1, 1'b0, 0);
        push_order(OP_CONV, 32'hC, 4'b0000, 1'b0, 1'b0, 0);
        wait_retires("illegal_retire", rets + 1, 20);
        check("finish_before", 64'(finish), 64'd0);
        wait_retires("finish_retire", rets + 2, 20);
        check("min_period", 64'(last_ret_cyc - prev_ret_cyc), 64'd5);
        tick(10);
        check("finish_set", 64'(finish), 64'd1);
        check("finish_pop_blocked", 64'(pop_order_en), 64'd0);
        check("finish_third_not_popped", 64'(rd_ptr), 64'(wr_ptr - 1));
        check("no_start_illegal_finish", 64'(start_seen), 64'(starts));
        check("finish_busy", 64'(busy), 64'd0);
        check("sb_start_empty", 64'(exp_start.size()), 64'd0);
        check("sb_retire_empty", 64'(exp_ret.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
